z80_bus_arbiter: RTL and testbench
==================================

# z80_bus_arbiter

Shares the test SoC's single RAM port between the z80 core and a host/debug port by means of the core's bus-request handshake. A host access first asserts `_busrq` and waits for `_busak`. It then switches the RAM address, data and write mux to the host side, performs one or more timed RAM accesses, and finally returns the bus to the core. The block sits between `chip_z80`, `ram_6502` and the testbench/loader, all in the `eclk` domain.

## Interface
Parameters:
- `ACCESS_CYCLES`, default 4: `eclk` cycles per host RAM access, covering RAM setup and read sample; legal range 2..15.
- `TIMEOUT_CYCLES`, default 1024: maximum `eclk` cycles spent waiting for `_busak`. Used only when `Z80_ARB_TIMEOUT_EN` is defined.

Ports (name, direction, width, meaning):
- `eclk` in 1: system clock.
- `ereset` in 1: reset, synchronous, active-high.
- `host_req` in 1: host access request; held high until `host_ack`.
- `host_we` in 1: 1 = write, 0 = read; sampled together with `host_req`.
- `host_addr` in 16: host address.
- `host_wdata` in 8: host write data.
- `host_last` in 1: 1 = release the bus after this access; 0 = keep ownership for a burst.
- `host_rdata` out 8: read data; valid while `host_ack`=1.
- `host_ack` out 1: one-cycle completion pulse.
- `host_err` out 1: one-cycle pulse together with `host_ack` on timeout.
- `host_owns` out 1: 1 while the host owns the RAM bus.
- `_busrq` out 1: bus request to the z80, active-low.
- `_busak` in 1: bus acknowledge from the z80, active-low.
- `cpu_ab` in 16: z80 address.
- `cpu_db_o` in 8: z80 write data.
- `cpu_wr_n` in 1: z80 write strobe.
- `ram_ab` out 16: RAM address.
- `ram_din` out 8: RAM write data.
- `ram_wr_n` out 1: RAM write strobe, active-low.
- `ram_dout` in 8: RAM read data.

## Operation
- States: IDLE, REQ, OWN, ACCESS, REL.
- IDLE: `_busrq`=1 and `host_owns`=0. The mux passes `cpu_ab`, `cpu_db_o` and `cpu_wr_n` straight through, combinationally. IDLE goes to REQ when `host_req`=1.
- REQ: `_busrq`=0. The block goes to OWN on the first cycle in which `_busak`=0 is sampled.
- OWN: `host_owns`=1 and `ram_wr_n`=1. The mux selects the host side. The host address, write data, write enable and `host_last` are latched and the block goes to ACCESS.
- ACCESS: counts `ACCESS_CYCLES`.
  - Write: `ram_wr_n`=0 for every ACCESS cycle except the last, which returns it to 1 for address hold.
  - Read: `ram_dout` is captured into `host_rdata` on the last ACCESS cycle.
  - On exit, `host_ack` pulses. If latched `host_last`=1 the block goes to REL. Otherwise it goes to OWN and waits there, keeping the bus, until the next `host_req`.
- REL: the mux is back to the CPU side and `_busrq`=1. The block waits for `_busak`=1, then goes to IDLE. New requests are not accepted until IDLE.
- Boundary cases:
  - `host_req` dropped before `host_ack` is a protocol violation. The block completes the latched access anyway.
  - `host_req` and `_busak` both changing in the same cycle: the state register acts only on sampled values; there is no combinational path from `_busak` to `_busrq`.
  - `ereset` mid-access: next edge gives IDLE, `_busrq`=1, CPU mux selected and the counter cleared. Any partial write is lost.

## Timing
- Reset values: `_busrq`=1, `host_ack`=0, `host_err`=0, `host_owns`=0, `host_rdata`=0. `ram_*` follow the CPU inputs.
- Latency from `host_req` to `host_ack` when the bus is not yet owned is 1 + N + 1 + `ACCESS_CYCLES` cycles, where N is the number of cycles until `_busak`=0.
- Burst access within ownership: 1 + `ACCESS_CYCLES` cycles per access.
- Mux select (`host_owns`) is registered. It changes only on entry to OWN and on entry to REL, so `ram_wr_n` never glitches low during handover.
- The access counter is 4 bits and saturation-free. It reloads with `ACCESS_CYCLES`-1 on entry to ACCESS.

## Configuration
- `Z80_ARB_TIMEOUT_EN` defined:
  - REQ counts cycles. At `TIMEOUT_CYCLES` without `_busak`=0, the block pulses `host_ack` and `host_err`, sets `host_rdata`=0 and goes to REL.
  - The counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide.
- `Z80_ARB_TIMEOUT_EN` undefined: REQ waits indefinitely, `host_err` is tied to 0, and no timeout counter is built.

## Structure
- Package `z80_arb_pkg`: state enum `arb_state_t` (IDLE, REQ, OWN, ACCESS, REL) and the constant `ARB_CNT_W`=4.
- One sub-module, `arb_down_counter`: a loadable down-counter with a zero flag, width parameterised. It is instantiated for the access counter, and for the timeout counter under the macro.
- Everything else, including the FSM, latches and mux, sits in the top module.

## Test plan
- Single write: `_busak` is returned 3 cycles after `_busrq`=0; host writes 0xA5 to 0x1234 with `host_last`=1 -> `ram_wr_n` low for 3 cycles at 0x1234, `host_ack` 9 cycles after `host_req`, `_busrq`=1 afterwards, CPU mux restored once `_busak`=1.
- Burst read of 4 bytes from 0x0100..0x0103 with `host_last` only on the 4th -> `_busrq` stays low throughout, each `host_ack` comes 5 cycles after its request, `host_rdata` matches the preloaded RAM contents.
- Reset during ACCESS of a write -> next cycle `_busrq`=1 and `host_owns`=0, no further `ram_wr_n` low, `host_ack` never pulses.
- Handover glitch check: CPU holds `cpu_wr_n`=0 at 0x0010 across the grant -> no cycle with `ram_ab`=host address while `ram_wr_n`=0 from the CPU.
- Under `Z80_ARB_TIMEOUT_EN` with `TIMEOUT_CYCLES`=16 and `_busak` held 1 -> `host_ack` and `host_err` pulse together 17 cycles after `host_req`, `_busrq` returns to 1, and no RAM write occurs.

Source files
------------

// File: rtl/z80_arb_pkg.sv
// Shared types for the z80 / host RAM bus arbiter.
// Optional REQ timeout is enabled with Z80_ARB_TIMEOUT_EN.
package z80_arb_pkg;

    localparam int ARB_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        OWN,
        ACCESS,
        REL
    } arb_state_t;

endpackage

// File: rtl/z80_bus_arbiter_counter.sv
// Loadable down-counter with zero flag, used for access and timeout timing.
module arb_down_counter #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/z80_bus_arbiter.sv
// Shares the RAM port between the z80 core and a host port via BUSRQ/BUSAK.
// Define Z80_ARB_TIMEOUT_EN to bound the wait for BUSAK.
module z80_bus_arbiter
    import z80_arb_pkg::*;
#(
    parameter int ACCESS_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        eclk,
    input  logic        ereset,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [15:0] host_addr,
    input  logic [7:0]  host_wdata,
    input  logic        host_last,
    output logic [7:0]  host_rdata,
    output logic        host_ack,
    output logic        host_err,
    output logic        host_owns,
    output logic        _busrq,
    input  logic        _busak,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_db_o,
    input  logic        cpu_wr_n,
    output logic [15:0] ram_ab,
    output logic [7:0]  ram_din,
    output logic        ram_wr_n,
    input  logic [7:0]  ram_dout
);

    if (ACCESS_CYCLES < 2 || ACCESS_CYCLES > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("z80_bus_arbiter: parameter out of range");
    end

    localparam logic [ARB_CNT_W-1:0] ACC_LOAD = ARB_CNT_W'(ACCESS_CYCLES - 1);

    arb_state_t  state_q;
    logic        busrq_q;
    logic        owns_q;
    logic        ack_q;
    logic        pend_q;
    logic        we_q;
    logic        last_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;

    logic acc_load;
    logic acc_dec;
    logic acc_zero;
    logic host_wr_n;

    // pend_q lets OWN finish an accepted access even if host_req was dropped.
    assign acc_load = (state_q == OWN) && (host_req || pend_q);
    assign acc_dec  = (state_q == ACCESS) && !acc_zero;

    arb_down_counter #(
        .W(ARB_CNT_W)
    ) u_acc_cnt (
        .clk_i     (eclk),
        .rst_i     (ereset),
        .load_i    (acc_load),
        .load_val_i(ACC_LOAD),
        .dec_i     (acc_dec),
        .zero_o    (acc_zero)
    );

`ifdef Z80_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

    logic to_load;
    logic to_dec;
    logic to_zero;
    logic err_q;

    assign to_load = (state_q == IDLE) && host_req;
    assign to_dec  = (state_q == REQ) && _busak && !to_zero;

    arb_down_counter #(
        .W(TO_W)
    ) u_to_cnt (
        .clk_i     (eclk),
        .rst_i     (ereset),
        .load_i    (to_load),
        .load_val_i(TO_LOAD),
        .dec_i     (to_dec),
        .zero_o    (to_zero)
    );

    assign host_err = err_q;
`else
    assign host_err = 1'b0;
`endif

    always_ff @(posedge eclk) begin
        if (ereset) begin
            state_q <= IDLE;
            busrq_q <= 1'b1;
            owns_q  <= 1'b0;
            ack_q   <= 1'b0;
            pend_q  <= 1'b0;
            we_q    <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef Z80_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
`ifdef Z80_ARB_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (host_req) begin
                        state_q <= REQ;
                        busrq_q <= 1'b0;
                        pend_q  <= 1'b1;
                        we_q    <= host_we;
                        last_q  <= host_last;
                        addr_q  <= host_addr;
                        wdata_q <= host_wdata;
                    end
                end
                REQ: begin
                    if (!_busak) begin
                        state_q <= OWN;
                        owns_q  <= 1'b1;
`ifdef Z80_ARB_TIMEOUT_EN
                    end else if (to_zero) begin
                        state_q <= REL;
                        busrq_q <= 1'b1;
                        pend_q  <= 1'b0;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
`endif
                    end
                end
                OWN: begin
                    if (acc_load) begin
                        state_q <= ACCESS;
                        pend_q  <= 1'b0;
                        if (host_req) begin
                            we_q    <= host_we;
                            last_q  <= host_last;
                            addr_q  <= host_addr;
                            wdata_q <= host_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (acc_zero) begin
                        ack_q <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= ram_dout;
                        end
                        if (last_q) begin
                            state_q <= REL;
                            busrq_q <= 1'b1;
                            owns_q  <= 1'b0;
                        end else begin
                            state_q <= OWN;
                        end
                    end
                end
                REL: begin
                    if (_busak) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Last ACCESS cycle keeps the strobe high so the address is held.
    assign host_wr_n = !((state_q == ACCESS) && we_q && !acc_zero);

    assign ram_ab   = owns_q ? addr_q    : cpu_ab;
    assign ram_din  = owns_q ? wdata_q   : cpu_db_o;
    assign ram_wr_n = owns_q ? host_wr_n : cpu_wr_n;

    assign host_rdata = rdata_q;
    assign host_ack   = ack_q;
    assign host_owns  = owns_q;
    assign _busrq     = busrq_q;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Randomized bench for z80_bus_arbiter against a transaction-level model.
// Timeout case runs only when Z80_ARB_TIMEOUT_EN is defined.
module tb_z80_bus_arbiter;

    localparam int ACC = 4;
    localparam int TO  = 16;

    logic        eclk = 1'b0;
    logic        ereset;
    logic        host_req;
    logic        host_we;
    logic [15:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_last;
    logic [7:0]  host_rdata;
    logic        host_ack;
    logic        host_err;
    logic        host_owns;
    logic        _busrq;
    logic        _busak;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_db_o;
    logic        cpu_wr_n;
    logic [15:0] ram_ab;
    logic [7:0]  ram_din;
    logic        ram_wr_n;
    logic [7:0]  ram_dout;

    int checks;
    int failures;
    int cyc;
    int busak_dly;
    int rq_cnt;
    bit z80_hold;

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];

    z80_bus_arbiter #(
        .ACCESS_CYCLES (ACC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .eclk      (eclk),
        .ereset    (ereset),
        .host_req  (host_req),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_wdata(host_wdata),
        .host_last (host_last),
        .host_rdata(host_rdata),
        .host_ack  (host_ack),
        .host_err  (host_err),
        .host_owns (host_owns),
        ._busrq    (_busrq),
        ._busak    (_busak),
        .cpu_ab    (cpu_ab),
        .cpu_db_o  (cpu_db_o),
        .cpu_wr_n  (cpu_wr_n),
        .ram_ab    (ram_ab),
        .ram_din   (ram_din),
        .ram_wr_n  (ram_wr_n),
        .ram_dout  (ram_dout)
    );

    always #5 eclk = ~eclk;

    always @(posedge eclk) cyc <= cyc + 1;

    assign ram_dout = mem[ram_ab];

    always @(posedge eclk) begin
        if (!ram_wr_n) mem[ram_ab] <= ram_din;
    end

    // z80 stand-in: grants busak_dly edges after seeing busrq low.
    always @(posedge eclk) begin
        if (ereset || _busrq) begin
            rq_cnt <= 0;
            _busak <= 1'b1;
        end else begin
            rq_cnt <= rq_cnt + 1;
            _busak <= !((rq_cnt + 1 >= busak_dly) && !z80_hold);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic host_xfer(input bit we, input logic [15:0] a, input logic [7:0] d,
                             input bit last, input int exp_lat, input bit exp_err);
        int  start;
        int  lowc;
        bit  got;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
        host_last  = last;
        start = cyc;
        lowc  = 0;
        got   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge eclk);
            if (!ram_wr_n && ram_ab == a) lowc++;
            if (host_ack) begin
                got = 1'b1;
                break;
            end
        end
        check("ack_seen", 32'(got), 32'd1);
        if (got) begin
            check("latency", 32'(cyc - start), 32'(exp_lat));
            check("err", 32'(host_err), 32'(exp_err));
            if (exp_err) check("rdata_err", 32'(host_rdata), 32'd0);
            else if (!we) check("rdata", 32'(host_rdata), 32'(ref_mem[a]));
            check("wr_low", 32'(lowc), (we && !exp_err) ? 32'(ACC - 1) : 32'd0);
            check("busrq_after", 32'(_busrq), 32'(last | exp_err));
            check("owns_after", 32'(host_owns), 32'(!(last | exp_err)));
        end
        if (we && !exp_err) ref_mem[a] = d;
        host_req = 1'b0;
    endtask

    task automatic release_wait();
        repeat (3) @(negedge eclk);
        check("rel_busrq", 32'(_busrq), 32'd1);
        check("rel_owns", 32'(host_owns), 32'd0);
        check("rel_mux_ab", 32'(ram_ab), 32'(cpu_ab));
        check("rel_mux_wr", 32'(ram_wr_n), 32'(cpu_wr_n));
    endtask

    initial begin
        int n;
        int acks;
        int lows;
        logic [15:0] a;
        ereset     = 1'b1;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        host_last  = 1'b0;
        cpu_ab     = 16'h4321;
        cpu_db_o   = 8'h5A;
        cpu_wr_n   = 1'b1;
        busak_dly  = 2;
        z80_hold   = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge eclk);
        check("rst_busrq", 32'(_busrq), 32'd1);
        check("rst_ack", 32'(host_ack), 32'd0);
        check("rst_err", 32'(host_err), 32'd0);
        check("rst_owns", 32'(host_owns), 32'd0);
        check("rst_rdata", 32'(host_rdata), 32'd0);
        check("rst_ab", 32'(ram_ab), 32'h4321);
        check("rst_din", 32'(ram_din), 32'h5A);
        check("rst_wr", 32'(ram_wr_n), 32'd1);
        ereset = 1'b0;
        repeat (2) @(negedge eclk);

        busak_dly = 2;
        host_xfer(1'b1, 16'h1234, 8'hA5, 1'b1, 9, 1'b0);
        release_wait();
        check("mem_1234", 32'(mem[16'h1234]), 32'hA5);

        busak_dly = $urandom_range(1, 4);
        for (int k = 0; k < 4; k++) begin
            host_xfer(1'b0, 16'h0100 + 16'(k), 8'h00, k == 3,
                      (k == 0) ? (busak_dly + 3 + ACC) : (1 + ACC), 1'b0);
            if (k != 3) check("burst_busrq", 32'(_busrq), 32'd0);
        end
        release_wait();

        for (int b = 0; b < 20; b++) begin
            cpu_ab    = 16'($urandom);
            cpu_db_o  = 8'($urandom);
            busak_dly = $urandom_range(1, 4);
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                a = 16'h0100 | 16'($urandom_range(0, 255));
                host_xfer(1'($urandom), a, 8'($urandom), k == n - 1,
                          (k == 0) ? (busak_dly + 3 + ACC) : (1 + ACC), 1'b0);
                repeat ($urandom_range(0, 2)) @(negedge eclk);
            end
            release_wait();
        end
        for (int i = 16'h0100; i < 16'h0200; i++) begin
            if (mem[i] !== ref_mem[i]) check("mem_scan", 32'(mem[i]), 32'(ref_mem[i]));
        end
        check("mem_scan_0100", 32'(mem[16'h0100]), 32'(ref_mem[16'h0100]));

        cpu_ab    = 16'h0010;
        cpu_db_o  = 8'h3C;
        cpu_wr_n  = 1'b0;
        busak_dly = 1;
        host_xfer(1'b0, 16'h0200, 8'h00, 1'b1, busak_dly + 3 + ACC, 1'b0);
        release_wait();
        cpu_wr_n = 1'b1;
        cpu_ab   = 16'h4321;
        @(negedge eclk);

        busak_dly  = 1;
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 16'h0300;
        host_wdata = 8'h77;
        host_last  = 1'b1;
        repeat (6) @(negedge eclk);
        check("mid_write_wr", 32'(ram_wr_n), 32'd0);
        check("mid_write_ab", 32'(ram_ab), 32'h0300);
        ereset   = 1'b1;
        host_req = 1'b0;
        @(negedge eclk);
        ereset = 1'b0;
        check("rstmid_busrq", 32'(_busrq), 32'd1);
        check("rstmid_owns", 32'(host_owns), 32'd0);
        acks = 0;
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            if (host_ack) acks++;
            if (!ram_wr_n) lows++;
            @(negedge eclk);
        end
        check("rstmid_acks", 32'(acks), 32'd0);
        check("rstmid_wrlow", 32'(lows), 32'd0);

`ifdef Z80_ARB_TIMEOUT_EN
        z80_hold = 1'b1;
        host_xfer(1'b1, 16'h0400, 8'h99, 1'b1, 1 + TO, 1'b1);
        release_wait();
        z80_hold = 1'b0;
        check("to_mem", 32'(mem[16'h0400]), 32'(ref_mem[16'h0400]));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
